saturn_bus_sequencer: RTL
=========================

// Module: saturn_bus_sequencer
// PURPOSE
//  Parametrised successor of the Saturn 4-phase bus controller. Buffers command/data nibbles from the
//  control unit in a depth-configurable FIFO, drives one bus transfer per 4-phase cycle, and runs
//  counted read bursts, returning captured nibbles to the control unit. Sits between control unit and bus.
// PARAMETERS
//  DEPTH    16  program FIFO entries; power of two, >= 2
//  DATA_W   4   bus nibble width in bits
//  RDCNT_W  5   width of the read-burst counter; max burst is 2**RDCNT_W-1
// PORTS
//  i_clk            in   1         system clock
//  i_reset_n        in   1         asynchronous reset, active low
//  i_clk_en         in   1         global clock enable
//  i_debug_hold     in   1         debugger owns cycle; sequencer frozen
//  i_phases         in   4         one-hot phase (0001,0010,0100,1000)
//  i_push           in   1         write entry {i_push_cmd,i_push_data} into FIFO
//  i_push_cmd       in   1         1 = command nibble, 0 = data nibble
//  i_push_data      in   DATA_W    nibble to send
//  o_full           out  1         FIFO holds DEPTH entries
//  o_level          out  log2(DEPTH)+1  current FIFO occupancy
//  i_rd_start       in   1         load read-burst counter
//  i_rd_count       in   RDCNT_W   number of nibbles to read
//  o_rd_valid       out  1         one-cycle strobe, o_rd_data valid
//  o_rd_data        out  DATA_W    captured bus nibble
//  o_busy           out  1         transfers pending or in flight
//  o_error          out  1         sticky: overflow or illegal read start
//  o_bus_clk_en     out  1         bus strobe
//  o_bus_is_data    out  1         1 = data transfer, 0 = command
//  o_bus_nibble_out out  DATA_W    nibble driven onto bus
//  i_bus_nibble_in  in   DATA_W    nibble from bus
// BEHAVIOUR
//  - Reset (async, i_reset_n=0): FIFO empty, pointers 0, read count 0, state IDLE, all outputs 0
//    except o_busy=0; o_level=0. Release mid-burst abandons the burst without a strobe.
//  - Advance = i_clk_en && !i_debug_hold. Pushes and i_rd_start are accepted on any cycle with
//    i_clk_en=1 (independent of hold); all bus and state activity requires advance.
//  - Push: accepted if !o_full, or if a pop occurs the same cycle. Push when full without pop:
//    entry dropped, o_error<=1. Push+pop same cycle: level unchanged. Pointers wrap modulo DEPTH.
//  - Push sets o_busy<=1 next cycle. i_rd_start with count>0 loads counter, sets o_busy. i_rd_start
//    while counter!=0 is ignored and sets o_error; count=0 is a no-op.
//  - FSM states IDLE, WRITE, READ; evaluated only on phase 0001 with advance:
//    FIFO non-empty -> WRITE: pop head, o_bus_is_data<=!cmd, o_bus_nibble_out<=data, o_bus_clk_en<=1.
//    else counter!=0 -> READ: o_bus_is_data<=1, o_bus_clk_en<=1, nibble_out held.
//    else -> IDLE, no strobe. Writes always take priority over reads.
//  - Phase 0010: o_bus_clk_en<=0. In READ: o_rd_data<=i_bus_nibble_in, o_rd_valid<=1 (one clock),
//    counter decrements. State returns to IDLE.
//  - Phase 0100: if FIFO empty and counter==0 and no strobe asserted, o_busy<=0.
//  - Phase 1000: no action. Non-one-hot i_phases: no action.
//  - Latency: pushed nibble appears on bus at the next phase-0001 edge if FIFO was empty.
// CONFIGURATION
//  SATURN_BUS_LOOPBACK_CHECK_EN defined: in WRITE, phase 0010 compares i_bus_nibble_in with the
//  nibble driven; mismatch sets o_error (sticky). Undefined: bus input ignored during WRITE, no check.
// TESTING
//  - Reset: i_reset_n=0 mid-WRITE -> all outputs 0 immediately, o_level=0 after release.
//  - Push CMD 5, DATA A, DATA 3 -> three phase cycles drive (is_data,nib)=(0,5),(1,A),(1,3);
//    o_busy falls in phase 0100 of the third cycle.
//  - Fill DEPTH=16, push 17th with no pop -> dropped, o_error=1, o_level=16; push on pop cycle accepted.
//  - Read burst count 3, bus returns 7,8,9 -> three o_rd_valid strobes with data 7,8,9, counter 0, busy 0.
//  - Push during active read burst -> next phase-0001 performs WRITE, burst resumes after FIFO empties.
//  - i_debug_hold=1 across two phase cycles with FIFO non-empty -> no bus strobes, level unchanged;
//    with loopback EN, bus returns B for driven A -> o_error=1.

Source files
------------

// File: rtl/saturn_bus_sequencer.sv
// saturn_bus_sequencer
// Buffers command/data nibbles from the control unit in a FIFO, drives one bus
// transfer per 4-phase cycle and runs counted read bursts, returning captured
// nibbles as one-clock strobes. Writes always win over pending reads.
// Optional feature: define SATURN_BUS_LOOPBACK_CHECK_EN to compare the bus input
// against the driven nibble during a write and flag a mismatch on o_error.
module saturn_bus_sequencer #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 4,
    parameter int RDCNT_W = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_clk_en,
    input  logic                   i_debug_hold,
    input  logic [3:0]             i_phases,
    input  logic                   i_push,
    input  logic                   i_push_cmd,
    input  logic [DATA_W-1:0]      i_push_data,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level,
    input  logic                   i_rd_start,
    input  logic [RDCNT_W-1:0]     i_rd_count,
    output logic                   o_rd_valid,
    output logic [DATA_W-1:0]      o_rd_data,
    output logic                   o_busy,
    output logic                   o_error,
    output logic                   o_bus_clk_en,
    output logic                   o_bus_is_data,
    output logic [DATA_W-1:0]      o_bus_nibble_out,
    input  logic [DATA_W-1:0]      i_bus_nibble_in
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [3:0] PH_DRIVE   = 4'b0001;
    localparam logic [3:0] PH_CAPTURE = 4'b0010;
    localparam logic [3:0] PH_SETTLE  = 4'b0100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    typedef struct packed {
        logic              cmd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [RDCNT_W-1:0] rd_cnt;
    state_t             state;
    state_t             state_next;

    logic advance;
    logic empty;
    logic full;
    logic start_write;
    logic start_read;
    logic capture;
    logic settle;
    logic push_ok;
    logic push_drop;
    logic rd_load;
    logic rd_bad;
    logic loop_err;
    entry_t head;

    // Bus and state activity need advance; pushes and read starts only need the clock enable.
    assign advance   = i_clk_en && !i_debug_hold;
    assign empty     = (level == '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign head      = mem[rd_ptr];
    assign settle    = advance && (i_phases == PH_SETTLE);
    assign push_ok   = i_clk_en && i_push && (!full || start_write);
    assign push_drop = i_clk_en && i_push && full && !start_write;
    assign rd_load   = i_clk_en && i_rd_start && (rd_cnt == '0) && (i_rd_count != '0);
    assign rd_bad    = i_clk_en && i_rd_start && (rd_cnt != '0);
    assign o_full    = full;
    assign o_level   = level;

`ifdef SATURN_BUS_LOOPBACK_CHECK_EN
    assign loop_err = advance && (i_phases == PH_CAPTURE) && (state == WRITE)
                      && (i_bus_nibble_in != o_bus_nibble_out);
`else
    assign loop_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_next;
    end

    // Next-state logic: choose the transfer at phase 0001, close it at phase 0010.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next  = state;
        start_write = 1'b0;
        start_read  = 1'b0;
        capture     = 1'b0;
        if (advance && (i_phases == PH_DRIVE)) begin
            if (!empty) begin
                state_next  = WRITE;
                start_write = 1'b1;
            end else if (rd_cnt != '0) begin
                state_next = READ;
                start_read = 1'b1;
            end else begin
                state_next = IDLE;
            end
        end else if (advance && (i_phases == PH_CAPTURE)) begin
            state_next = IDLE;
            capture    = (state == READ);
        end
    end

    // FIFO storage write port.
    // NOTE: storage has no reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= '{cmd: i_push_cmd, data: i_push_data};
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)     wr_ptr <= wr_ptr + 1'b1;
            if (start_write) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, start_write})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Read-burst counter: loaded only when idle, decremented on each captured nibble.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)   rd_cnt <= '0;
        else if (rd_load) rd_cnt <= i_rd_count;
        else if (capture) rd_cnt <= rd_cnt - 1'b1;
    end

    // Registered bus, read-return and status outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_bus_clk_en     <= 1'b0;
            o_bus_is_data    <= 1'b0;
            o_bus_nibble_out <= '0;
            o_rd_valid       <= 1'b0;
            o_rd_data        <= '0;
            o_busy           <= 1'b0;
            o_error          <= 1'b0;
        end else begin
            o_rd_valid <= 1'b0;
            if (start_write) begin
                o_bus_clk_en     <= 1'b1;
                o_bus_is_data    <= !head.cmd;
                o_bus_nibble_out <= head.data;
            end else if (start_read) begin
                o_bus_clk_en  <= 1'b1;
                o_bus_is_data <= 1'b1;
            end else if (advance && (i_phases == PH_CAPTURE)) begin
                o_bus_clk_en <= 1'b0;
            end
            if (capture) begin
                o_rd_data  <= i_bus_nibble_in;
                o_rd_valid <= 1'b1;
            end
            if (push_drop || rd_bad || loop_err) o_error <= 1'b1;
            if (push_ok || rd_load) begin
                o_busy <= 1'b1;
            end else if (settle && empty && (rd_cnt == '0) && !o_bus_clk_en) begin
                o_busy <= 1'b0;
            end
        end
    end

endmodule
